data_ram_responder: RTL and testbench



---
 rtl/data_ram_responder_pkg.sv | 36 +++
 rtl/data_ram_responder_byte_lane_align.sv | 75 +++++++
 rtl/data_ram_responder.sv | 194 +++++++++++++++++++
 tb/tb_data_ram_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_responder_pkg.sv
// ----------------------------------------------------------------------------
// data_ram_responder_pkg
// Shared types and constants for the data-memory responder.
//   mem_size_e  : RV32I load/store funct3 encodings understood by the responder
//   ram_state_e : responder FSM states
//   WAIT_CNT_W  : width of the wait-state counter (WAIT_STATES is 0..15)
//   size_legal(): 1 when a size code is a legal access for the given direction
// ----------------------------------------------------------------------------
package data_ram_responder_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } ram_state_e;

    localparam int WAIT_CNT_W = 4;

    // Unsigned sizes only exist for loads; 011/110/111 are never legal.
    function automatic logic size_legal(input logic [2:0] size, input logic we);
        case (size)
            SZ_B, SZ_H, SZ_W: size_legal = 1'b1;
            SZ_BU, SZ_HU:     size_legal = ~we;
            default:          size_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_responder_byte_lane_align.sv
// ----------------------------------------------------------------------------
// data_ram_responder_byte_lane_align
// Combinational byte-lane steering between the right-aligned CPU data and the
// word-wide RAM.
//   size_i     : access size (funct3)
//   addr_lo_i  : byte offset within the word, already naturally aligned
//   wdata_i    : right-aligned store data
//   rword_i    : raw word read from the RAM
//   be_o       : write byte-enable mask
//   wword_o    : store data shifted onto its byte lanes (unused lanes zero)
//   rdata_o    : load data extracted from its lane and sign/zero extended
// ----------------------------------------------------------------------------
module data_ram_responder_byte_lane_align
    import data_ram_responder_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o
);

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        is_byte = (size_i == SZ_B) || (size_i == SZ_BU);
        is_half = (size_i == SZ_H) || (size_i == SZ_HU);
        is_word = (size_i == SZ_W);
    end

    always_comb begin
        be_o = 4'b0000;
        if (is_byte) begin
            be_o = 4'b0001 << addr_lo_i;
        end else if (is_half) begin
            be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        end else if (is_word) begin
            be_o = 4'b1111;
        end
    end

    // Each lane picks its source byte: bytes replicate wdata[7:0], halves
    // replicate wdata[15:0] (even lanes low byte, odd lanes high byte).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam int HALF_SEL = gi % 2;
            assign wword_o[gi*8 +: 8] =
                !be_o[gi] ? 8'h00 :
                is_byte   ? wdata_i[7:0] :
                is_half   ? wdata_i[HALF_SEL*8 +: 8] :
                            wdata_i[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        rbyte = rword_i[{addr_lo_i, 3'b000} +: 8];
        rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SZ_B:    rdata_o = {{24{rbyte[7]}}, rbyte};
            SZ_H:    rdata_o = {{16{rhalf[15]}}, rhalf};
            SZ_W:    rdata_o = rword_i;
            SZ_BU:   rdata_o = {24'h000000, rbyte};
            SZ_HU:   rdata_o = {16'h0000, rhalf};
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_ram_responder.sv
// ----------------------------------------------------------------------------
// data_ram_responder
// Target end of the core's load/store bus backed by a synchronous word RAM.
// One request at a time, WAIT_STATES wait cycles, then a one-cycle response.
//   clk, reset   : clock, asynchronous active-high reset
//   bus_req      : request valid, sampled only in IDLE
//   bus_we       : 1 = store, 0 = load
//   bus_addr     : byte address
//   bus_wdata    : right-aligned store data
//   bus_size     : RV32I funct3 of the access
//   bus_ready    : one-cycle response strobe
//   bus_rdata    : extended load data (held until the next response)
//   bus_err      : error flag (held until the next response)
// Build option: define DATA_RAM_MISALIGN_TRAP_EN to make misaligned half/word
// accesses error; otherwise the offending low address bits are cleared.
// ----------------------------------------------------------------------------
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [2:0]  bus_size,
    output logic        bus_ready,
    output logic [31:0] bus_rdata,
    output logic        bus_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [WAIT_CNT_W-1:0] WS_LAST = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);

    ram_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                   we_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic [2:0]             size_q;
    logic                   ready_q;
    logic                   err_q;
    logic                   load_ok_q;
    logic [31:0]            rdata_hold_q;
    logic [31:0]            rword_q;
    logic [31:0]            mem_q [0:DEPTH-1];

    logic                   accept;
    logic                   enter_resp;
    logic                   cur_we;
    logic [31:0]            cur_addr;
    logic [31:0]            cur_wdata;
    logic [2:0]             cur_size;
    logic [31:0]            offset;
    logic                   in_range;
    logic                   misalign_err;
    logic                   cur_err;
    logic [1:0]             addr_lo;
    logic [ADDR_WIDTH-1:0]  idx;
    logic [3:0]             be;
    logic [31:0]            wword;
    logic [31:0]            rdata_ext;
    logic [31:0]            rdata_resp;

    // With WAIT_STATES=0 the RAM is accessed on the accepting edge itself,
    // before the request fields are latched, so IDLE looks at the bus directly.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = bus_we;
            cur_addr  = bus_addr;
            cur_wdata = bus_wdata;
            cur_size  = bus_size;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_size  = size_q;
        end
    end

    always_comb begin
        offset   = cur_addr - BASE_ADDR;
        in_range = (cur_addr >= BASE_ADDR) && (offset[31:ADDR_WIDTH+2] == '0);
        idx      = offset[ADDR_WIDTH+1:2];
        addr_lo  = cur_addr[1:0];
        if (cur_size[1:0] == 2'b01) begin
            addr_lo[0] = 1'b0;
        end else if (cur_size == SZ_W) begin
            addr_lo = 2'b00;
        end
    end

`ifdef DATA_RAM_MISALIGN_TRAP_EN
    assign misalign_err = ((cur_size[1:0] == 2'b01) && cur_addr[0]) ||
                          ((cur_size == SZ_W) && (cur_addr[1:0] != 2'b00));
`else
    assign misalign_err = 1'b0;
`endif

    assign cur_err = !in_range || !size_legal(cur_size, cur_we) || misalign_err;

    data_ram_responder_byte_lane_align u_align (
        .size_i    (cur_size),
        .addr_lo_i (addr_lo),
        .wdata_i   (cur_wdata),
        .rword_i   (rword_q),
        .be_o      (be),
        .wword_o   (wword),
        .rdata_o   (rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus_req) begin
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt_q + CNT_ONE == WS_LAST) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept     = (state_q == IDLE) && bus_req;
    // Gated by reset so nothing reaches the RAM while the FSM is held in IDLE.
    assign enter_resp = (state_d == RESP) && (state_q != RESP) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            load_ok_q    <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= enter_resp;
            if (accept) begin
                we_q    <= bus_we;
                addr_q  <= bus_addr;
                wdata_q <= bus_wdata;
                size_q  <= bus_size;
            end
            if (enter_resp) begin
                err_q     <= cur_err;
                load_ok_q <= !cur_we && !cur_err;
            end
            if (ready_q) begin
                rdata_hold_q <= rdata_resp;
            end
        end
    end

    // RAM: byte-masked write and registered read, both on the RESP-entry edge.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][b*8 +: 8] <= wword[b*8 +: 8];
                end
            end
        end
        if (enter_resp && !cur_we) begin
            rword_q <= mem_q[idx];
        end
    end

    assign rdata_resp = load_ok_q ? rdata_ext : 32'h0000_0000;
    assign bus_ready  = ready_q;
    assign bus_err    = err_q;
    assign bus_rdata  = ready_q ? rdata_resp : rdata_hold_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// ----------------------------------------------------------------------------
// tb_data_ram_responder
// Self-checking bench: directed accesses from the test plan plus randomized
// loads/stores checked against a byte-array reference model.
// ----------------------------------------------------------------------------
module tb_data_ram_responder;

    localparam int          AW        = 10;
    localparam int          WS        = 1;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          MEM_BYTES = 4 * (2 ** AW);

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [2:0]  bus_size;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [0:MEM_BYTES-1];

    data_ram_responder #(
        .ADDR_WIDTH  (AW),
        .WAIT_STATES (WS),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_size  (bus_size),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // Byte-level reference: decides legality, applies the store or builds
    // the extended load value.
    function automatic void model(input bit we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] size,
                                  output logic [31:0] rd, output bit err);
        int n;
        bit sgn;
        int a;
        logic [31:0] v;
        rd = 32'h0; err = 1'b0; n = 0; sgn = 1'b0;
        case (size)
            3'b000: begin n = 1; sgn = 1'b1; end
            3'b001: begin n = 2; sgn = 1'b1; end
            3'b010: n = 4;
            3'b100: n = 1;
            3'b101: n = 2;
            default: err = 1'b1;
        endcase
        if (we && size[2]) err = 1'b1;
        if (addr < BASE || (addr - BASE) >= MEM_BYTES) err = 1'b1;
        if (err) return;
        a = int'(addr - BASE);
        if (a % n != 0) begin
`ifdef DATA_RAM_MISALIGN_TRAP_EN
            err = 1'b1;
            return;
`else
            a = a - (a % n);
`endif
        end
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
            if (sgn && v[8*n-1]) begin
                for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
            end
            rd = v;
        end
    endfunction

    // One transaction: drive, wait for the strobe, compare latency/err/rdata
    // with the model and, if has_want, with an explicit expected value.
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] size, input string nm,
                             input bit has_want, input logic [31:0] want_rd, input bit want_err);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          k;
        model(we, addr, wdata, size, exp_rd, exp_err);
        @(negedge clk);
        bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata; bus_size = size;
        @(posedge clk);
        @(negedge clk);
        bus_req = 1'b0;
        k = 1;
        while (!bus_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: bus_ready=%b after %0d cycles, required 1", nm, bus_ready, k);
        end else begin
            checks++;
            if (k != WS + 1) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", nm, k, WS + 1);
            end
            checks++;
            if (bus_err !== exp_err) begin
                errors++;
                $display("FAIL %s err: got %b required %b", nm, bus_err, exp_err);
            end
            checks++;
            if (bus_rdata !== exp_rd) begin
                errors++;
                $display("FAIL %s rdata: got %h required %h", nm, bus_rdata, exp_rd);
            end
            if (has_want) begin
                checks++;
                if (bus_rdata !== want_rd || bus_err !== want_err) begin
                    errors++;
                    $display("FAIL %s const: got rdata=%h err=%b required rdata=%h err=%b",
                             nm, bus_rdata, bus_err, want_rd, want_err);
                end
            end
        end
        $display("txn %-10s we=%0d addr=%h wdata=%h size=%03b -> rdata=%h err=%b lat=%0d",
                 nm, we, addr, wdata, size, bus_rdata, bus_err, k);
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_req = 1'b0; bus_we = 1'b0;
        bus_addr = '0; bus_wdata = '0; bus_size = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_ready !== 1'b0 || bus_err !== 1'b0 || bus_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset: got ready=%b err=%b rdata=%h required 0/0/0",
                     bus_ready, bus_err, bus_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b required 0", bus_ready);
        end
    endtask

    task automatic test_preload();
        for (int w = 0; w < 64; w++) begin
            do_access(1'b1, BASE + 32'(w * 4), $urandom, 3'b010, "preload", 1'b0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_lanes();
        do_access(1, 32'h10, 32'hDEADBEEF, 3'b010, "SW", 1, 32'h0, 0);
        do_access(0, 32'h10, 32'h0,        3'b010, "LW", 1, 32'hDEADBEEF, 0);
        do_access(1, 32'h13, 32'h00000080, 3'b000, "SB", 1, 32'h0, 0);
        do_access(0, 32'h13, 32'h0,        3'b000, "LB", 1, 32'hFFFFFF80, 0);
        do_access(0, 32'h13, 32'h0,        3'b100, "LBU", 1, 32'h00000080, 0);
        do_access(0, 32'h10, 32'h0,        3'b010, "LW_b", 1, 32'h80ADBEEF, 0);
        do_access(1, 32'h12, 32'h00008001, 3'b001, "SH", 1, 32'h0, 0);
        do_access(0, 32'h12, 32'h0,        3'b001, "LH", 1, 32'hFFFF8001, 0);
        do_access(0, 32'h12, 32'h0,        3'b101, "LHU", 1, 32'h00008001, 0);
        do_access(0, 32'h10, 32'h0,        3'b010, "LW_h", 1, 32'h8001BEEF, 0);
    endtask

    task automatic test_hold();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus_ready !== 1'b0 || bus_rdata !== 32'h8001BEEF || bus_err !== 1'b0) begin
                errors++;
                $display("FAIL hold: got ready=%b rdata=%h err=%b required 0/8001beef/0",
                         bus_ready, bus_rdata, bus_err);
            end
        end
    endtask

    task automatic test_errors();
        do_access(0, 32'h1000, 32'h0,        3'b010, "LW_oob", 1, 32'h0, 1);
        do_access(1, 32'h1000, 32'hCAFEF00D, 3'b010, "SW_oob", 1, 32'h0, 1);
        do_access(0, 32'h0,    32'h0,        3'b010, "LW_w0", 0, 32'h0, 0);
        do_access(1, 32'h4,    32'h11223344, 3'b100, "S_bad", 1, 32'h0, 1);
        do_access(0, 32'h4,    32'h0,        3'b011, "L_bad", 1, 32'h0, 1);
        do_access(0, 32'h4,    32'h0,        3'b010, "LW_w1", 0, 32'h0, 0);
`ifdef DATA_RAM_MISALIGN_TRAP_EN
        do_access(0, 32'h11,   32'h0,        3'b010, "LW_mis", 1, 32'h0, 1);
`else
        do_access(0, 32'h11,   32'h0,        3'b010, "LW_mis", 1, 32'h8001BEEF, 0);
`endif
    endtask

    task automatic test_reset_midop();
        int seen;
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 32'h20;
        bus_wdata = 32'h12345678; bus_size = 3'b010;
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        bus_req = 1'b0;
        checks++;
        if (bus_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_ready_in_reset: got %b required 0", bus_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_ready) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midop_no_resp: got %0d strobes required 0", seen);
        end
        do_access(0, 32'h20, 32'h0, 3'b010, "LW_after_rst", 0, 32'h0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd;
        bit          exp_err;
        int          pulses;
        model(0, 32'h10, 32'h0, 3'b010, exp_rd, exp_err);
        @(negedge clk);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'h10; bus_size = 3'b010;
        pulses = 0;
        for (int c = 1; c <= 4 * (WS + 2); c++) begin
            @(negedge clk);
            if (bus_ready) begin
                checks++;
                if (c != (WS + 1) + pulses * (WS + 2) || bus_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL b2b_pulse%0d: got cycle %0d rdata=%h required cycle %0d rdata=%h",
                             pulses, c, bus_rdata, (WS + 1) + pulses * (WS + 2), exp_rd);
                end
                pulses++;
            end
        end
        bus_req = 1'b0;
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d required 4", pulses);
        end
        $display("txn b2b        %0d responses over %0d cycles", pulses, 4 * (WS + 2));
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0]  sz_tab [0:7];
        logic [31:0] addr;
        sz_tab[0] = 3'b000; sz_tab[1] = 3'b001; sz_tab[2] = 3'b010; sz_tab[3] = 3'b100;
        sz_tab[4] = 3'b101; sz_tab[5] = 3'b010; sz_tab[6] = 3'b011; sz_tab[7] = 3'b111;
        for (int i = 0; i < 40; i++) begin
            addr = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) addr = 32'h1000 + 32'($urandom_range(0, 4095));
            do_access(1'($urandom_range(0, 1)), addr, $urandom, sz_tab[$urandom_range(0, 7)],
                      "rand", 1'b0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_preload();
        test_lanes();
        test_hold();
        test_errors();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
